btb_predictor: RTL and testbench

- Parametrised branch target buffer with per-entry saturating direction counters.
- Supplies a next-PC prediction to the IF stage of the pipelined core in the same cycle the PC is presented.
- Trained by resolved branches and jumps from the EX/MEM stage.
- Removes the fixed taken-branch flush penalty on correctly predicted control flow.
- Counts lookup hits and mispredictions for performance analysis.

---
 rtl/btb_predictor.sv | 145 ++++++++++++++
 tb/tb_btb_predictor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with saturating direction
// counters, zero-latency lookup, registered training and saturating perf counters.
`default_nettype none

module btb_predictor #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              if_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispredict,
  input  logic              flush_all,
  output logic [PERF_W-1:0] perf_hits,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  // Table storage; only valid_q and cnt_q carry a reset value.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic               jump_q   [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [PERF_W-1:0]  perf_hits_q, perf_hits_d;
  logic [PERF_W-1:0]  perf_mispred_q, perf_mispred_d;

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[XLEN-1:IDX_W+2];

  assign lk_hit   = if_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);

  assign pred_hit    = lk_hit;
  assign pred_taken  = lk_taken;
  assign pred_target = lk_taken ? target_q[lk_idx] : (if_pc + XLEN'(4));

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             ent_we;
  logic [XLEN-1:0]  ent_target_d;
  logic             ent_jump_d;
  logic [CNT_W-1:0] ent_cnt_d;
  logic             unused_upd_lsb;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign unused_upd_lsb = ^upd_pc[1:0];

  always_comb begin
    ent_we       = 1'b0;
    ent_target_d = target_q[up_idx];
    ent_jump_d   = jump_q[up_idx];
    ent_cnt_d    = cnt_q[up_idx];
    if (upd_valid) begin
      if (up_hit) begin
        ent_we = 1'b1;
        if (upd_is_jump) begin
          ent_target_d = upd_target;
          ent_cnt_d    = CNT_MAX;
        end else if (upd_taken) begin
          ent_target_d = upd_target;
          ent_cnt_d    = (cnt_q[up_idx] == CNT_MAX) ? CNT_MAX : cnt_q[up_idx] + 1'b1;
        end else begin
          ent_cnt_d    = (cnt_q[up_idx] == '0) ? '0 : cnt_q[up_idx] - 1'b1;
        end
      end else if (upd_taken) begin
        // Allocation replaces whatever currently lives at this index.
        ent_we       = 1'b1;
        ent_target_d = upd_target;
        ent_jump_d   = upd_is_jump;
        ent_cnt_d    = upd_is_jump ? CNT_MAX : CNT_WT;
      end
    end
  end

  // ---------------------------------------------------------------- perf
  always_comb begin
    perf_hits_d    = perf_hits_q;
    perf_mispred_d = perf_mispred_q;
    if (lk_hit && (perf_hits_q != {PERF_W{1'b1}})) begin
      perf_hits_d = perf_hits_q + 1'b1;
    end
    if (upd_valid && upd_mispredict && (perf_mispred_q != {PERF_W{1'b1}})) begin
      perf_mispred_d = perf_mispred_q + 1'b1;
    end
  end

  assign perf_hits    = perf_hits_q;
  assign perf_mispred = perf_mispred_q;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q        <= '0;
      perf_hits_q    <= '0;
      perf_mispred_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else begin
      perf_hits_q    <= perf_hits_d;
      perf_mispred_q <= perf_mispred_d;
      if (flush_all) begin
        valid_q <= '0;
      end else if (ent_we) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= ent_target_d;
        jump_q[up_idx]   <= ent_jump_d;
        cnt_q[up_idx]    <= ent_cnt_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed test of btb_predictor against a table-level model
// checked every cycle, plus hand-computed literal checkpoints.
`default_nettype none

module tb_btb_predictor;
  localparam int XLEN = 64;
  localparam int ENT  = 16;
  localparam int CNTW = 2;
  localparam int PW   = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [XLEN-1:0] if_pc;
  logic            if_valid;
  logic            pred_hit, pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid, upd_is_jump, upd_taken, upd_mispredict, flush_all;
  logic [XLEN-1:0] upd_pc, upd_target;
  logic [PW-1:0]   perf_hits, perf_mispred;

  btb_predictor #(.XLEN(XLEN), .ENTRIES(ENT), .CNT_W(CNTW), .PERF_W(PW)) dut (
    .clk(clk), .rstn(rstn), .if_pc(if_pc), .if_valid(if_valid),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .flush_all(flush_all), .perf_hits(perf_hits), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // Model: one record per table slot, keyed by (pc/4) mod ENT, tag = pc / (4*ENT).
  bit              m_valid  [ENT];
  longint unsigned m_tag    [ENT];
  logic [XLEN-1:0] m_target [ENT];
  bit              m_jump   [ENT];
  int              m_cnt    [ENT];
  int              m_hits, m_misp;
  localparam int CMAX = (1 << CNTW) - 1;
  localparam int PMAX = (1 << PW) - 1;

  function automatic int slot(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % ENT);
  endfunction
  function automatic longint unsigned tagof(input logic [XLEN-1:0] pc);
    return pc / (4 * ENT);
  endfunction
  function automatic bit m_is_hit(input logic [XLEN-1:0] pc, input bit v);
    return v && m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
  endfunction
  function automatic bit m_is_taken(input logic [XLEN-1:0] pc, input bit v);
    return m_is_hit(pc, v) && (m_jump[slot(pc)] || m_cnt[slot(pc)] >= (1 << (CNTW - 1)));
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int s;
    if (!rstn) begin
      for (int i = 0; i < ENT; i++) begin
        m_valid[i] = 0;
        m_cnt[i]   = (1 << (CNTW - 1)) - 1;
      end
      m_hits = 0;
      m_misp = 0;
    end else begin
      if (m_is_hit(if_pc, if_valid) && m_hits < PMAX) m_hits++;
      if (upd_valid && upd_mispredict && m_misp < PMAX) m_misp++;
      s = slot(upd_pc);
      if (flush_all) begin
        for (int i = 0; i < ENT; i++) m_valid[i] = 0;
      end else if (upd_valid) begin
        if (m_is_hit(upd_pc, 1'b1)) begin
          if (upd_is_jump) begin
            m_target[s] = upd_target;
            m_cnt[s]    = CMAX;
          end else if (upd_taken) begin
            m_target[s] = upd_target;
            if (m_cnt[s] < CMAX) m_cnt[s]++;
          end else if (m_cnt[s] > 0) begin
            m_cnt[s]--;
          end
        end else if (upd_taken) begin
          m_valid[s]  = 1;
          m_tag[s]    = tagof(upd_pc);
          m_target[s] = upd_target;
          m_jump[s]   = upd_is_jump;
          m_cnt[s]    = upd_is_jump ? CMAX : (1 << (CNTW - 1));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit eh, et;
      eh = m_is_hit(if_pc, if_valid);
      et = m_is_taken(if_pc, if_valid);
      chk("cyc_hit", pred_hit, eh);
      chk("cyc_taken", pred_taken, et);
      chk("cyc_target", pred_target, et ? m_target[slot(if_pc)] : if_pc + 4);
      chk("cyc_perf_hits", perf_hits, m_hits);
      chk("cyc_perf_mispred", perf_mispred, m_misp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [XLEN-1:0] pc, input bit j, input bit t,
                     input logic [XLEN-1:0] tgt, input bit mp);
    upd_valid = 1; upd_pc = pc; upd_is_jump = j; upd_taken = t;
    upd_target = tgt; upd_mispredict = mp;
  endtask

  task automatic noupd();
    upd_valid = 0; upd_mispredict = 0;
  endtask

  task automatic look(input logic [XLEN-1:0] pc, input string n, input bit h,
                      input bit t, input logic [XLEN-1:0] tgt);
    if_pc = pc; if_valid = 1;
    #1;
    chk({n, "_hit"}, pred_hit, h);
    chk({n, "_taken"}, pred_taken, t);
    chk({n, "_target"}, pred_target, tgt);
  endtask

  initial begin
    rstn = 0; if_pc = 64'h8000_0010; if_valid = 1; flush_all = 0;
    upd_valid = 0; upd_pc = 0; upd_is_jump = 0; upd_taken = 0;
    upd_target = 0; upd_mispredict = 0;
    step(); step();
    rstn = 1;
    started = 1;

    look(64'h8000_0010, "reset", 0, 0, 64'h8000_0014);
    chk("reset_perf_hits", perf_hits, 0);
    chk("reset_perf_mispred", perf_mispred, 0);

    // Allocate; same-cycle lookup must still see the empty slot.
    upd(64'h8000_0010, 0, 1, 64'h8000_0100, 0);
    look(64'h8000_0010, "nobypass", 0, 0, 64'h8000_0014);
    step(); noupd();
    look(64'h8000_0010, "alloc", 1, 1, 64'h8000_0100);

    upd(64'h8000_0010, 0, 0, 64'h0, 0);
    step(); step(); noupd();
    look(64'h8000_0010, "cnt00", 1, 0, 64'h8000_0014);

    upd(64'h8000_0010, 0, 1, 64'h8000_0100, 0);
    repeat (5) step();
    noupd();
    look(64'h8000_0010, "sat11", 1, 1, 64'h8000_0100);
    upd(64'h8000_0010, 0, 0, 64'h0, 0);
    step(); noupd();
    look(64'h8000_0010, "cnt10", 1, 1, 64'h8000_0100);
    upd(64'h8000_0010, 0, 0, 64'h0, 0);
    step(); noupd();
    look(64'h8000_0010, "cnt01", 1, 0, 64'h8000_0014);

    // Aliasing: jal then branch at same index, different tag.
    flush_all = 1; step(); flush_all = 0;
    look(64'h8000_0010, "flushed", 0, 0, 64'h8000_0014);
    upd(64'h8000_0010, 1, 1, 64'h8000_0200, 0);
    step(); noupd();
    look(64'h8000_0010, "jal", 1, 1, 64'h8000_0200);
    upd(64'h8000_0050, 0, 1, 64'h8000_0300, 0);
    look(64'h8000_0050, "alias_old", 0, 0, 64'h8000_0054);
    step(); noupd();
    look(64'h8000_0010, "alias_evict", 0, 0, 64'h8000_0014);
    look(64'h8000_0050, "alias_new", 1, 1, 64'h8000_0300);

    // Flush beats a same-cycle update.
    upd(64'h8000_0020, 0, 1, 64'h8000_0400, 0);
    flush_all = 1; step(); flush_all = 0; noupd();
    look(64'h8000_0020, "flush_drop", 0, 0, 64'h8000_0024);
    look(64'h8000_0050, "flush_clr", 0, 0, 64'h8000_0054);

    // Perf counters from a clean reset.
    rstn = 0; step(); rstn = 1;
    chk("rst1_perf_hits", perf_hits, 0);
    if_valid = 0;
    upd(64'h8000_0030, 0, 1, 64'h8000_0500, 1);
    repeat (3) step();
    noupd();
    chk("misp3", perf_mispred, 3);
    chk("hits0", perf_hits, 0);
    if_pc = 64'h8000_0030; if_valid = 1;
    repeat (20) step();
    chk("hits_sat", perf_hits, 15);

    // Reset mid-count also discards the pending update.
    upd(64'h8000_0040, 1, 1, 64'h8000_0600, 1);
    rstn = 0; step(); rstn = 1; noupd();
    chk("rst2_perf_hits", perf_hits, 0);
    chk("rst2_perf_mispred", perf_mispred, 0);
    look(64'h8000_0040, "rst_drop", 0, 0, 64'h8000_0044);
    look(64'h8000_0030, "rst_clr", 0, 0, 64'h8000_0034);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
